// File: rtl/board_button_pulser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : board_button_pulser_pkg
// Brief   : Shared state encodings, 100 MHz timing defaults and counter sizing
//           for the push-button conditioner.
// Revision: 1.0 - initial release
// ============================================================================
package board_button_pulser_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_PRESS  = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_t;

    localparam int unsigned c_deb_cyc_100m    = 2_000_000;   // 20 ms
    localparam int unsigned c_repeat_dly_100m = 50_000_000;  // 0.5 s
    localparam int unsigned c_repeat_per_100m = 10_000_000;  // 0.1 s

    // One width covers both the debounce and the hold/repeat counter.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_button_pulser_if.sv
`default_nettype none
// ============================================================================
// Module  : board_button_pulser_if
// Brief   : Button pins in, debounced levels and press/release strobes out.
// Revision: 1.0 - initial release
// ============================================================================
interface board_button_pulser_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] rel_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  rel_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output rel_pulse
    );
endinterface
`default_nettype wire

// File: rtl/board_button_pulser_btn_channel.sv
`default_nettype none
// ============================================================================
// Module  : btn_channel
// Brief   : One button: 2-FF synchronizer, debounce counter and
//           IDLE/PRESS/REPEAT strobe FSM with registered outputs.
// Revision: 1.0 - initial release
// ============================================================================
module btn_channel
    import board_button_pulser_pkg::*;
#(
    parameter int unsigned DEB_CYC    = c_deb_cyc_100m,
    parameter int unsigned REPEAT_DLY = c_repeat_dly_100m,
    parameter int unsigned REPEAT_PER = c_repeat_per_100m,
    parameter bit          REPEAT_EN  = 1'b0
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_btn_raw,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_rel_pulse
);

    localparam int unsigned c_cnt_w = cnt_width(DEB_CYC, REPEAT_DLY, REPEAT_PER);

    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEB_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_dly_last = c_cnt_w'(REPEAT_DLY - 1);
    localparam logic [c_cnt_w-1:0] c_per_last = c_cnt_w'(REPEAT_PER - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic               r_press;
    logic               r_rel;
    logic [c_cnt_w-1:0] r_deb;
    logic [c_cnt_w-1:0] r_hold;
    btn_state_t         r_state;

    logic w_change;
    logic w_accept;

    assign w_change = (r_sync != r_level);
    assign w_accept = w_change && (r_deb == c_deb_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_deb   <= '0;
            r_hold  <= '0;
            r_state <= BTN_IDLE;
        end else begin
            r_meta  <= i_btn_raw;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            r_rel   <= 1'b0;

            if (!w_change || w_accept) begin
                r_deb <= '0;
            end else if (r_deb != c_cnt_max) begin
                r_deb <= r_deb + c_one;
            end

            if (w_accept) begin
                r_level <= r_sync;
            end

            // Release has priority over a repeat strobe due in the same cycle.
            case (r_state)
                BTN_IDLE: begin
                    r_hold <= '0;
                    if (w_accept && r_sync) begin
                        r_state <= BTN_PRESS;
                        r_press <= 1'b1;
                    end
                end
                BTN_PRESS: begin
                    if (w_accept && !r_sync) begin
                        r_state <= BTN_IDLE;
                        r_rel   <= 1'b1;
                        r_hold  <= '0;
                    end else if (REPEAT_EN) begin
                        if (r_hold == c_dly_last) begin
                            r_state <= BTN_REPEAT;
                            r_press <= 1'b1;
                            r_hold  <= '0;
                        end else if (r_hold != c_cnt_max) begin
                            r_hold <= r_hold + c_one;
                        end
                    end
                end
                BTN_REPEAT: begin
                    if (w_accept && !r_sync) begin
                        r_state <= BTN_IDLE;
                        r_rel   <= 1'b1;
                        r_hold  <= '0;
                    end else if (r_hold == c_per_last) begin
                        r_press <= 1'b1;
                        r_hold  <= '0;
                    end else if (r_hold != c_cnt_max) begin
                        r_hold <= r_hold + c_one;
                    end
                end
                default: begin
                    r_state <= BTN_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign o_btn_level   = r_level;
    assign o_press_pulse = r_press;
    assign o_rel_pulse   = r_rel;

endmodule
`default_nettype wire

// File: rtl/board_button_pulser.sv
`default_nettype none
// ============================================================================
// Module  : board_button_pulser
// Brief   : N independent button channels turning raw pins into debounced
//           levels and single-cycle press/release strobes.
// Revision: 1.0 - initial release
// ============================================================================
module board_button_pulser
    import board_button_pulser_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_CYC    = c_deb_cyc_100m,
    parameter int unsigned REPEAT_DLY = c_repeat_dly_100m,
    parameter int unsigned REPEAT_PER = c_repeat_per_100m,
    parameter bit          REPEAT_EN  = 1'b0
) (
    input  wire                   clk,
    input  wire                   rst_n,
    board_button_pulser_if.slave  bus
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_channel #(
            .DEB_CYC    (DEB_CYC),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER),
            .REPEAT_EN  (REPEAT_EN)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_btn_raw     (bus.btn_raw[gi]),
            .o_btn_level   (bus.btn_level[gi]),
            .o_press_pulse (bus.press_pulse[gi]),
            .o_rel_pulse   (bus.rel_pulse[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_board_button_pulser.sv
`default_nettype none
// ============================================================================
// Module  : tb_board_button_pulser
// Brief   : Directed scoreboard bench; dut0 without auto-repeat, dut1 with.
// Revision: 1.0 - initial release
// ============================================================================
module tb_board_button_pulser;

    localparam int unsigned c_deb = 4;
    localparam int unsigned c_dly = 20;
    localparam int unsigned c_per = 5;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] press;
        logic [3:0] rel;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   n_fail;
    exp_t q[$];

    logic [3:0] m_ep, m_er, m_op, m_or;

    board_button_pulser_if #(.N_BTN(4)) bus0 ();
    board_button_pulser_if #(.N_BTN(4)) bus1 ();

    board_button_pulser #(
        .N_BTN(4), .DEB_CYC(c_deb), .REPEAT_DLY(c_dly), .REPEAT_PER(c_per), .REPEAT_EN(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    board_button_pulser #(
        .N_BTN(4), .DEB_CYC(c_deb), .REPEAT_DLY(c_dly), .REPEAT_PER(c_per), .REPEAT_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int at, input int d, input logic [3:0] p, input logic [3:0] r);
        exp_t e;
        e.cyc = at; e.dut = d; e.press = p; e.rel = r;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe monitor: any strobe seen or due in this cycle is compared.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            m_ep = '0;
            m_er = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc && q[i].dut == d) begin
                    m_ep = m_ep | q[i].press;
                    m_er = m_er | q[i].rel;
                    q.delete(i);
                end
            end
            m_op = (d == 0) ? bus0.press_pulse : bus1.press_pulse;
            m_or = (d == 0) ? bus0.rel_pulse   : bus1.rel_pulse;
            if (|{m_ep, m_er, m_op, m_or}) begin
                check($sformatf("press_d%0d_c%0d", d, cyc), 32'(m_op), 32'(m_ep));
                check($sformatf("rel_d%0d_c%0d", d, cyc), 32'(m_or), 32'(m_er));
            end
        end
    end

    initial begin
        int a;
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus0.btn_raw = 4'b0000;
        bus1.btn_raw = 4'b0000;

        tick(3);
        check("rst_level0", 32'(bus0.btn_level), 32'h0);
        check("rst_press0", 32'(bus0.press_pulse), 32'h0);
        check("rst_rel0", 32'(bus0.rel_pulse), 32'h0);
        check("rst_level1", 32'(bus1.btn_level), 32'h0);
        rst_n = 1'b1;
        tick(4);
        check("idle_level0", 32'(bus0.btn_level), 32'h0);

        // 1: clean press on btn0, no auto-repeat on dut0
        bus0.btn_raw[0] = 1'b1;
        push(cyc + 6, 0, 4'b0001, 4'b0000);
        tick(8);
        check("t1_level", 32'(bus0.btn_level), 32'h1);
        tick(30);
        bus0.btn_raw[0] = 1'b0;
        push(cyc + 6, 0, 4'b0000, 4'b0001);
        tick(8);
        check("t1_level_rel", 32'(bus0.btn_level), 32'h0);

        // 2: bouncing press on btn1
        bus0.btn_raw[1] = 1'b1; tick(2);
        bus0.btn_raw[1] = 1'b0; tick(2);
        bus0.btn_raw[1] = 1'b1; tick(2);
        bus0.btn_raw[1] = 1'b0; tick(2);
        check("t2_level_bounce", 32'(bus0.btn_level), 32'h0);
        bus0.btn_raw[1] = 1'b1;
        push(cyc + 6, 0, 4'b0010, 4'b0000);
        tick(8);
        check("t2_level", 32'(bus0.btn_level), 32'h2);
        bus0.btn_raw[1] = 1'b0;
        push(cyc + 6, 0, 4'b0000, 4'b0010);
        tick(8);

        // 3: auto-repeat on dut1 btn2; release lands where the next repeat would
        bus1.btn_raw[2] = 1'b1;
        a = cyc + 6;
        push(a,      1, 4'b0100, 4'b0000);
        push(a + 20, 1, 4'b0100, 4'b0000);
        push(a + 25, 1, 4'b0100, 4'b0000);
        push(a + 30, 1, 4'b0100, 4'b0000);
        push(a + 35, 1, 4'b0100, 4'b0000);
        tick(10);
        check("t3_level_hold", 32'(bus1.btn_level), 32'h4);
        while (cyc < a + 34) @(negedge clk);
        bus1.btn_raw[2] = 1'b0;
        push(cyc + 6, 1, 4'b0000, 4'b0100);
        tick(8);
        check("t3_level_rel", 32'(bus1.btn_level), 32'h0);

        // 4: simultaneous presses on btn0 and btn3
        bus0.btn_raw = 4'b1001;
        push(cyc + 6, 0, 4'b1001, 4'b0000);
        tick(8);
        check("t4_level", 32'(bus0.btn_level), 32'h9);
        bus0.btn_raw = 4'b0000;
        push(cyc + 6, 0, 4'b0000, 4'b1001);
        tick(8);

        // 5: reset pulse while btn1 is held
        bus0.btn_raw[1] = 1'b1;
        push(cyc + 6, 0, 4'b0010, 4'b0000);
        tick(10);
        check("t5_level_pre", 32'(bus0.btn_level), 32'h2);
        rst_n = 1'b0;
        #1;
        check("t5_level_rst", 32'(bus0.btn_level), 32'h0);
        check("t5_press_rst", 32'(bus0.press_pulse), 32'h0);
        check("t5_rel_rst", 32'(bus0.rel_pulse), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push(cyc + 6, 0, 4'b0010, 4'b0000);
        tick(8);
        check("t5_level_post", 32'(bus0.btn_level), 32'h2);
        bus0.btn_raw[1] = 1'b0;
        push(cyc + 6, 0, 4'b0000, 4'b0010);
        tick(8);

        // 6: 3-cycle low glitch during a hold on btn2
        bus0.btn_raw[2] = 1'b1;
        push(cyc + 6, 0, 4'b0100, 4'b0000);
        tick(8);
        bus0.btn_raw[2] = 1'b0;
        tick(3);
        bus0.btn_raw[2] = 1'b1;
        tick(10);
        check("t6_level", 32'(bus0.btn_level), 32'h4);
        bus0.btn_raw[2] = 1'b0;
        push(cyc + 6, 0, 4'b0000, 4'b0100);
        tick(8);
        check("t6_level_rel", 32'(bus0.btn_level), 32'h0);

        tick(5);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
